// File: rtl/accel_loader.sv
// Byte-stream packet loader: decodes INSTR / DATA / START packets into instruction writes,
// data-memory writes and bounded ce runs. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
`timescale 1ns/1ps
module accel_loader #(
  parameter int NUM_SIZE   = 16,
  parameter int BUFFER_LEN = 32,
  parameter int RUN_CYCLES = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          instr_we,
  output logic [4:0]                    instr_addr,
  output logic [23:0]                   instr_wdata,
  output logic                          mem_we,
  output logic [$clog2(BUFFER_LEN)-1:0] mem_addr,
  output logic [NUM_SIZE-1:0]           mem_wdata,
  output logic                          ce,
  output logic                          busy,
  output logic                          pkt_err
);

  localparam int AW = $clog2(BUFFER_LEN);
  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam logic [1:0] T_INSTR = 2'b00;
  localparam logic [1:0] T_DATA  = 2'b01;
  localparam logic [1:0] T_START = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    COMMIT,
    RUN
  } state_t;

  state_t          state;
  logic [1:0]      typ;
  logic [4:0]      addr;
  logic [2:0]      cnt;
  logic [31:0]     shreg;
  logic [RW-1:0]   run_cnt;
  logic [31:0]     word;
  logic            xfer;
  logic            commit_go;
  logic            run_go;
  logic            addr_ok;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign xfer    = in_valid && in_ready;
  assign busy    = (state != IDLE);
  assign addr_ok = ({27'd0, addr} < 32'(BUFFER_LEN));

  // While the last payload byte is on the bus the word includes it; otherwise it is already shifted in.
  always_comb begin
    word = (state == PAYLOAD) ? {shreg[23:0], in_data} : shreg;
  end

  always_comb begin
    commit_go = 1'b0;
    run_go    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    if (state == CHECK && xfer && in_data == csum) begin
      commit_go = (typ != T_START);
      run_go    = (typ == T_START);
    end
`else
    commit_go = (state == PAYLOAD) && xfer && (cnt == 3'd1);
    run_go    = (state == IDLE) && xfer && (in_data[7:6] == T_START);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      typ         <= 2'b00;
      addr        <= 5'd0;
      cnt         <= 3'd0;
      shreg       <= 32'd0;
      run_cnt     <= '0;
      in_ready    <= 1'b0;
      instr_we    <= 1'b0;
      instr_addr  <= 5'd0;
      instr_wdata <= 24'd0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ce          <= 1'b0;
      pkt_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= 8'd0;
`endif
    end else begin
      instr_we <= 1'b0;
      mem_we   <= 1'b0;
      pkt_err  <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (xfer) begin
            typ   <= in_data[7:6];
            addr  <= in_data[4:0];
            shreg <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum  <= in_data;
`endif
            case (in_data[7:6])
              T_INSTR: begin
                cnt   <= 3'd3;
                state <= PAYLOAD;
              end
              T_DATA: begin
                cnt   <= 3'(NUM_SIZE / 8);
                state <= PAYLOAD;
              end
`ifdef LOADER_CHECKSUM_EN
              T_START: state <= CHECK;
`else
              T_START: ;
`endif
              default: pkt_err <= 1'b1;
            endcase
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            shreg <= word;
            cnt   <= cnt - 3'd1;
`ifdef LOADER_CHECKSUM_EN
            csum  <= csum ^ in_data;
            if (cnt == 3'd1) state <= CHECK;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer && in_data != csum) begin
            pkt_err <= 1'b1;
            state   <= IDLE;
          end
        end
`endif
        COMMIT: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        RUN: begin
          if (run_cnt == '0) begin
            ce       <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            run_cnt <= run_cnt - RW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Packet completion overrides the per-state defaults above.
      if (commit_go) begin
        state    <= COMMIT;
        in_ready <= 1'b0;
        if (typ == T_INSTR) begin
          instr_we    <= 1'b1;
          instr_addr  <= addr;
          instr_wdata <= word[23:0];
        end else if (addr_ok) begin
          mem_we    <= 1'b1;
          mem_addr  <= addr[AW-1:0];
          mem_wdata <= word[NUM_SIZE-1:0];
        end else begin
          pkt_err <= 1'b1;
        end
      end
      if (run_go) begin
        state    <= RUN;
        in_ready <= 1'b0;
        ce       <= 1'b1;
        run_cnt  <= RW'(RUN_CYCLES - 1);
      end
    end
  end

endmodule
